// File: rtl/bicg_engine.sv
// BiCG sub-kernel: q = A*p and s = A^T*r over an N x N matrix held in external memory,
// using one Avalon-MM master with a single outstanding access and a start/busy/done/stall call interface.
module bicg_engine #(
  parameter int N      = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic                  stall,
  input  logic [ADDR_W-1:0]     A,
  input  logic [ADDR_W-1:0]     s,
  input  logic [ADDR_W-1:0]     q,
  input  logic [ADDR_W-1:0]     p,
  input  logic [ADDR_W-1:0]     r,
  output logic [ADDR_W-1:0]     avmm_0_rw_address,
  output logic [DATA_W/8-1:0]   avmm_0_rw_byteenable,
  output logic                  avmm_0_rw_read,
  input  logic [DATA_W-1:0]     avmm_0_rw_readdata,
  input  logic                  avmm_0_rw_readdatavalid,
  input  logic                  avmm_0_rw_waitrequest,
  output logic                  avmm_0_rw_write,
  output logic [DATA_W-1:0]     avmm_0_rw_writedata
);
  localparam int IW = $clog2(N);
  localparam logic [ADDR_W-1:0] BYTES = ADDR_W'(DATA_W / 8);
  localparam logic [IW-1:0]     LAST  = IW'(N - 1);

  typedef enum logic [2:0] {IDLE, RD_R, RD_A, RD_P, WR_Q, WR_S, DONE} state_t;

  state_t            state_q, state_d;
  logic              wait_q, wait_d;  // read accepted, now waiting for readdatavalid
  logic [IW-1:0]     i_q, i_d;
  logic [IW-1:0]     j_q, j_d;        // column index, reused as k while draining s
  logic [ADDR_W-1:0] a_base_q, a_base_d, s_base_q, s_base_d, q_base_q, q_base_d;
  logic [ADDR_W-1:0] p_base_q, p_base_d, r_base_q, r_base_d;
  logic [DATA_W-1:0] r_i_q, r_i_d, a_ij_q, a_ij_d, q_acc_q, q_acc_d;
  logic [DATA_W-1:0] s_acc_q [N];
  logic [DATA_W-1:0] s_acc_d [N];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      wait_q   <= 1'b0;
      i_q      <= '0;
      j_q      <= '0;
      a_base_q <= '0;
      s_base_q <= '0;
      q_base_q <= '0;
      p_base_q <= '0;
      r_base_q <= '0;
      r_i_q    <= '0;
      a_ij_q   <= '0;
      q_acc_q  <= '0;
      for (int k = 0; k < N; k++) s_acc_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      i_q      <= i_d;
      j_q      <= j_d;
      a_base_q <= a_base_d;
      s_base_q <= s_base_d;
      q_base_q <= q_base_d;
      p_base_q <= p_base_d;
      r_base_q <= r_base_d;
      r_i_q    <= r_i_d;
      a_ij_q   <= a_ij_d;
      q_acc_q  <= q_acc_d;
      s_acc_q  <= s_acc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    i_d      = i_q;
    j_d      = j_q;
    a_base_d = a_base_q;
    s_base_d = s_base_q;
    q_base_d = q_base_q;
    p_base_d = p_base_q;
    r_base_d = r_base_q;
    r_i_d    = r_i_q;
    a_ij_d   = a_ij_q;
    q_acc_d  = q_acc_q;
    s_acc_d  = s_acc_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_base_d = A;
          s_base_d = s;
          q_base_d = q;
          p_base_d = p;
          r_base_d = r;
          for (int k = 0; k < N; k++) s_acc_d[k] = '0;
          i_d     = '0;
          wait_d  = 1'b0;
          state_d = RD_R;
        end
      end
      RD_R, RD_A, RD_P: begin
        if (!wait_q) begin
          if (!avmm_0_rw_waitrequest) wait_d = 1'b1;
        end else if (avmm_0_rw_readdatavalid) begin
          wait_d = 1'b0;
          if (state_q == RD_R) begin
            r_i_d   = avmm_0_rw_readdata;
            q_acc_d = '0;
            j_d     = '0;
            state_d = RD_A;
          end else if (state_q == RD_A) begin
            a_ij_d  = avmm_0_rw_readdata;
            state_d = RD_P;
          end else begin
            // products and sums wrap at DATA_W bits
            s_acc_d[j_q] = s_acc_q[j_q] + r_i_q * a_ij_q;
            q_acc_d      = q_acc_q + a_ij_q * avmm_0_rw_readdata;
            if (j_q == LAST) begin
              state_d = WR_Q;
            end else begin
              j_d     = j_q + 1'b1;
              state_d = RD_A;
            end
          end
        end
      end
      WR_Q: begin
        if (!avmm_0_rw_waitrequest) begin
          if (i_q == LAST) begin
            j_d     = '0;
            state_d = WR_S;
          end else begin
            i_d     = i_q + 1'b1;
            state_d = RD_R;
          end
        end
      end
      WR_S: begin
        if (!avmm_0_rw_waitrequest) begin
          if (j_q == LAST) state_d = DONE;
          else             j_d     = j_q + 1'b1;
        end
      end
      DONE: begin
        if (!stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy                 = (state_q != IDLE);
  assign done                 = (state_q == DONE);
  assign avmm_0_rw_read       = (state_q == RD_R || state_q == RD_A || state_q == RD_P) && !wait_q;
  assign avmm_0_rw_write      = (state_q == WR_Q || state_q == WR_S);
  assign avmm_0_rw_byteenable = (avmm_0_rw_read || avmm_0_rw_write) ? '1 : '0;

  always_comb begin
    avmm_0_rw_address   = '0;
    avmm_0_rw_writedata = '0;
    case (state_q)
      RD_R: avmm_0_rw_address = r_base_q + ADDR_W'(i_q) * BYTES;
      RD_A: avmm_0_rw_address = a_base_q + (ADDR_W'(i_q) * ADDR_W'(N) + ADDR_W'(j_q)) * BYTES;
      RD_P: avmm_0_rw_address = p_base_q + ADDR_W'(j_q) * BYTES;
      WR_Q: begin
        avmm_0_rw_address   = q_base_q + ADDR_W'(i_q) * BYTES;
        avmm_0_rw_writedata = q_acc_q;
      end
      WR_S: begin
        avmm_0_rw_address   = s_base_q + ADDR_W'(j_q) * BYTES;
        avmm_0_rw_writedata = s_acc_q[j_q];
      end
      default: ;
    endcase
  end
endmodule
